// File: rtl/mtc_sl_receiver.sv
// MTC2SL receiver: per-channel FIFOs for incoming MTC words, merged round-robin onto one ready/valid stream.
// Optional procflags statistics (cnt_pass/cnt_below/cnt_other) are built when MTC_RX_FLAG_CNT_EN is defined.
module mtc_sl_receiver #(
  parameter int N_MTC                    = 3,
  parameter int FIFO_DEPTH               = 8,
  parameter int CNT_WIDTH                = 16,
  parameter int MTC2SL_LEN               = 32,
  parameter int MTC2SL_MDT_PROCFLAGS_MSB = 23,
  parameter int MTC2SL_MDT_PROCFLAGS_LSB = 20,
  localparam int CH_W = (N_MTC > 1) ? $clog2(N_MTC) : 1
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [MTC2SL_LEN-1:0] mtc [N_MTC],
  output logic [MTC2SL_LEN-2:0] out_data,
  output logic [CH_W-1:0]       out_ch,
  output logic [3:0]            out_procflags,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_MTC-1:0]      ovf_sticky,
  output logic [CNT_WIDTH-1:0]  drop_cnt
`ifdef MTC_RX_FLAG_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  cnt_pass,
  output logic [CNT_WIDTH-1:0]  cnt_below,
  output logic [CNT_WIDTH-1:0]  cnt_other
`endif
);

  localparam int PKT_W = MTC2SL_LEN - 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_MTC - 1);

  logic [PKT_W-1:0] mem    [N_MTC][FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr [N_MTC];
  logic [AW-1:0]    rd_ptr [N_MTC];
  logic [AW:0]      count  [N_MTC];

  logic [N_MTC-1:0] nonempty, full, push, pop, drop;
  logic             load, grant_valid;
  logic [CH_W-1:0]  grant, rr, rr_next;
  logic [PKT_W-1:0] head;
  logic [3:0]       head_flags;
  logic [CNT_WIDTH:0] drop_sum;
  int               cand;

  // Output handshake: a word moves downstream on any edge where out_valid & out_ready;
  // the register reloads when empty or on that transfer, and holds every field otherwise.
  assign load = !out_valid || out_ready;

  always_comb begin
    nonempty = '0;
    full     = '0;
    for (int i = 0; i < N_MTC; i++) begin
      nonempty[i] = (count[i] != '0);
      full[i]     = (count[i] == DEPTH_C);
    end
  end

  // Scan from rr downwards-priority: the last hit in a descending scan is the first after rr.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    cand        = 0;
    for (int k = N_MTC - 1; k >= 0; k--) begin
      cand = int'(rr) + k;
      if (cand >= N_MTC) cand = cand - N_MTC;
      if (nonempty[cand]) begin
        grant_valid = 1'b1;
        grant       = CH_W'(cand);
      end
    end
  end

  assign rr_next = (grant == LAST_CH) ? '0 : grant + 1'b1;

  always_comb begin
    head = '0;
    for (int i = 0; i < N_MTC; i++) begin
      if (grant == CH_W'(i)) head = mem[i][rd_ptr[i]];
    end
  end

  assign head_flags = head[MTC2SL_MDT_PROCFLAGS_MSB:MTC2SL_MDT_PROCFLAGS_LSB];

  // A full FIFO still accepts a write when it is popped on the same edge.
  always_comb begin
    push     = '0;
    pop      = '0;
    drop     = '0;
    drop_sum = {1'b0, drop_cnt};
    for (int i = 0; i < N_MTC; i++) begin
      pop[i]   = load && grant_valid && (grant == CH_W'(i));
      push[i]  = mtc[i][MTC2SL_LEN-1] && (!full[i] || pop[i]);
      drop[i]  = mtc[i][MTC2SL_LEN-1] && full[i] && !pop[i];
      drop_sum = drop_sum + {{CNT_WIDTH{1'b0}}, drop[i]};
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_MTC; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= mtc[i][PKT_W-1:0];
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_MTC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_MTC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (pop[i] && !push[i]) count[i] <= count[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_ch        <= '0;
      out_procflags <= '0;
      rr            <= '0;
      ovf_sticky    <= '0;
      drop_cnt      <= '0;
    end else begin
      if (load) begin
        out_valid <= grant_valid;
        if (grant_valid) begin
          out_data      <= head;
          out_ch        <= grant;
          out_procflags <= head_flags;
          rr            <= rr_next;
        end
      end
      ovf_sticky <= ovf_sticky | drop;
      drop_cnt   <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
    end
  end

`ifdef MTC_RX_FLAG_CNT_EN
  // Counted when a word enters the output register, not when it leaves.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt_pass  <= '0;
      cnt_below <= '0;
      cnt_other <= '0;
    end else if (load && grant_valid) begin
      if (head_flags == 4'h1) begin
        if (cnt_pass != '1) cnt_pass <= cnt_pass + 1'b1;
      end else if (head_flags == 4'h2) begin
        if (cnt_below != '1) cnt_below <= cnt_below + 1'b1;
      end else if (head_flags != 4'h0) begin
        if (cnt_other != '1) cnt_other <= cnt_other + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mtc_sl_receiver.sv
// Directed bench for mtc_sl_receiver: latency, round-robin order, overflow, full+pop, flags, async reset.
module tb_mtc_sl_receiver;
  localparam int N   = 3;
  localparam int LEN = 32;
  localparam int PW  = LEN - 1;
  localparam int CW  = 16;

  logic           clock = 1'b0;
  logic           rst   = 1'b1;
  logic [LEN-1:0] mtc [N];
  logic [PW-1:0]  out_data;
  logic [1:0]     out_ch;
  logic [3:0]     out_procflags;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   ovf_sticky;
  logic [CW-1:0]  drop_cnt;
`ifdef MTC_RX_FLAG_CNT_EN
  logic [CW-1:0]  cnt_pass, cnt_below, cnt_other;
`endif

  int total = 0;
  int bad   = 0;
  logic [PW-1:0] exp_q[$];
  logic [1:0]    exp_ch_q[$];

  mtc_sl_receiver #(
    .N_MTC(N), .FIFO_DEPTH(8), .CNT_WIDTH(CW), .MTC2SL_LEN(LEN),
    .MTC2SL_MDT_PROCFLAGS_MSB(23), .MTC2SL_MDT_PROCFLAGS_LSB(20)
  ) dut (
    .clock(clock), .rst(rst), .mtc(mtc),
    .out_data(out_data), .out_ch(out_ch), .out_procflags(out_procflags),
    .out_valid(out_valid), .out_ready(out_ready),
    .ovf_sticky(ovf_sticky), .drop_cnt(drop_cnt)
`ifdef MTC_RX_FLAG_CNT_EN
    , .cnt_pass(cnt_pass), .cnt_below(cnt_below), .cnt_other(cnt_other)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [LEN-1:0] mk(input logic [3:0] pf, input logic [PW-1:0] body);
    logic [PW-1:0] p;
    p = body;
    p[23:20] = pf;
    return {1'b1, p};
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) mtc[i] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clock);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL rst_data got=%h want=0", out_data); end
    total++; if (out_ch !== 2'd0) begin bad++; $display("FAIL rst_ch got=%0d want=0", out_ch); end
    total++; if (out_procflags !== 4'h0) begin bad++; $display("FAIL rst_pf got=%h want=0", out_procflags); end
    total++; if (ovf_sticky !== 3'b000) begin bad++; $display("FAIL rst_ovf got=%b want=000", ovf_sticky); end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL rst_drop got=%0d want=0", drop_cnt); end
`ifdef MTC_RX_FLAG_CNT_EN
    total++; if ({cnt_pass, cnt_below, cnt_other} !== 48'd0) begin
      bad++; $display("FAIL rst_cnt got=%0d/%0d/%0d want=0/0/0", cnt_pass, cnt_below, cnt_other);
    end
`endif
  endtask

  task automatic test_latency();
    logic [LEN-1:0] w;
    w = mk(4'h1, 31'h25A1_2345);
    mtc[1] = w;
    out_ready = 1'b1;
    @(posedge clock); #1;
    mtc[1] = '0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_early got=%b want=0", out_valid); end
    @(posedge clock); #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got=%b want=1", out_valid); end
    total++; if (out_ch !== 2'd1) begin bad++; $display("FAIL lat_ch got=%0d want=1", out_ch); end
    total++; if (out_procflags !== 4'h1) begin bad++; $display("FAIL lat_pf got=%h want=1", out_procflags); end
    total++; if (out_data !== w[PW-1:0]) begin bad++; $display("FAIL lat_data got=%h want=%h", out_data, w[PW-1:0]); end
`ifdef MTC_RX_FLAG_CNT_EN
    total++; if (cnt_pass !== 16'd1) begin bad++; $display("FAIL lat_cnt_pass got=%0d want=1", cnt_pass); end
`endif
    @(posedge clock); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_round_robin();
    logic [LEN-1:0] w;
    logic [PW-1:0]  d;
    logic [1:0]     ch;
    do_reset();
    out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < N; i++) begin
        w = mk(4'(i + 1), 31'h0000_0100 * 31'(b + 1) + 31'(i));
        mtc[i] = w;
        exp_q.push_back(w[PW-1:0]);
        exp_ch_q.push_back(2'(i));
      end
      @(posedge clock); #1;
      clear_inputs();
      for (int c = 0; c < N; c++) begin
        @(posedge clock); #1;
        d  = exp_q.pop_front();
        ch = exp_ch_q.pop_front();
        total++; if (out_valid !== 1'b1 || out_ch !== ch) begin
          bad++; $display("FAIL rr_order burst=%0d got v=%b ch=%0d want v=1 ch=%0d", b, out_valid, out_ch, ch);
        end
        total++; if (out_data !== d) begin
          bad++; $display("FAIL rr_data burst=%0d got=%h want=%h", b, out_data, d);
        end
      end
      @(posedge clock); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rr_idle got=%b want=0", out_valid); end
    end
  endtask

  task automatic test_overflow();
    logic [LEN-1:0] wv [10];
    do_reset();
    for (int j = 0; j < 10; j++) begin
      wv[j] = mk(4'h3, 31'h4000_0000 + 31'(j));
      mtc[0] = wv[j];
      @(posedge clock); #1;
      if (j >= 1) begin
        total++; if (out_valid !== 1'b1 || out_data !== wv[0][PW-1:0]) begin
          bad++; $display("FAIL ovf_stall cyc=%0d got v=%b d=%h want v=1 d=%h", j, out_valid, out_data, wv[0][PW-1:0]);
        end
      end
      if (j == 8) begin
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL ovf_pre got=%0d want=0", drop_cnt); end
      end
    end
    clear_inputs();
    total++; if (drop_cnt !== 16'd1) begin bad++; $display("FAIL ovf_drop got=%0d want=1", drop_cnt); end
    total++; if (ovf_sticky !== 3'b001) begin bad++; $display("FAIL ovf_sticky got=%b want=001", ovf_sticky); end
    out_ready = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      @(posedge clock); #1;
      total++; if (out_valid !== 1'b1 || out_data !== wv[j][PW-1:0]) begin
        bad++; $display("FAIL ovf_drain idx=%0d got v=%b d=%h want v=1 d=%h", j, out_valid, out_data, wv[j][PW-1:0]);
      end
    end
    @(posedge clock); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b want=0", out_valid); end
  endtask

  task automatic test_full_pop();
    logic [LEN-1:0] wv [10];
    do_reset();
    for (int j = 0; j < 10; j++) wv[j] = mk(4'h2, 31'h1230_0000 + 31'(j));
    for (int j = 0; j < 9; j++) begin
      mtc[2] = wv[j];
      @(posedge clock); #1;
    end
    mtc[2] = wv[9];
    out_ready = 1'b1;
    @(posedge clock); #1;
    clear_inputs();
    total++; if (drop_cnt !== 16'd0 || ovf_sticky !== 3'b000) begin
      bad++; $display("FAIL fp_nodrop got drop=%0d ovf=%b want 0/000", drop_cnt, ovf_sticky);
    end
    for (int j = 1; j <= 9; j++) begin
      total++; if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== wv[j][PW-1:0]) begin
        bad++; $display("FAIL fp_drain idx=%0d got v=%b ch=%0d d=%h want v=1 ch=2 d=%h",
                        j, out_valid, out_ch, out_data, wv[j][PW-1:0]);
      end
      @(posedge clock); #1;
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fp_empty got=%b want=0", out_valid); end
  endtask

  task automatic test_invalid_and_flags();
    logic [3:0]     pfs [4];
    logic [LEN-1:0] wv  [4];
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) mtc[i] = 32'h7ABC_DEF0 + 32'(i);
    repeat (3) begin
      @(posedge clock); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL inv_out got=%b want=0", out_valid); end
    end
    clear_inputs();
    total++; if (drop_cnt !== 16'd0 || ovf_sticky !== 3'b000) begin
      bad++; $display("FAIL inv_drop got drop=%0d ovf=%b want 0/000", drop_cnt, ovf_sticky);
    end
`ifdef MTC_RX_FLAG_CNT_EN
    total++; if ({cnt_pass, cnt_below, cnt_other} !== 48'd0) begin
      bad++; $display("FAIL inv_cnt got=%0d/%0d/%0d want=0/0/0", cnt_pass, cnt_below, cnt_other);
    end
`endif
    pfs = '{4'h0, 4'h2, 4'h6, 4'hF};
    for (int j = 0; j < 4; j++) wv[j] = mk(pfs[j], 31'h0012_3000 + 31'(j));
    for (int j = 0; j <= 4; j++) begin
      if (j < 4) mtc[0] = wv[j];
      else       mtc[0] = '0;
      @(posedge clock); #1;
      if (j > 0) begin
        total++; if (out_valid !== 1'b1 || out_procflags !== pfs[j-1] || out_data !== wv[j-1][PW-1:0]) begin
          bad++; $display("FAIL pf_fwd idx=%0d got v=%b pf=%h d=%h want v=1 pf=%h d=%h",
                          j - 1, out_valid, out_procflags, out_data, pfs[j-1], wv[j-1][PW-1:0]);
        end
      end
    end
`ifdef MTC_RX_FLAG_CNT_EN
    total++; if (cnt_pass !== 16'd0 || cnt_below !== 16'd1 || cnt_other !== 16'd2) begin
      bad++; $display("FAIL pf_cnt got=%0d/%0d/%0d want=0/1/2", cnt_pass, cnt_below, cnt_other);
    end
`endif
  endtask

  task automatic test_multi_drop();
    do_reset();
    for (int j = 0; j < 10; j++) begin
      for (int i = 0; i < N; i++) mtc[i] = mk(4'h0, 31'h0000_0500 + 31'(j * 4 + i));
      @(posedge clock); #1;
      if (j == 7) begin
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL md_pre got=%0d want=0", drop_cnt); end
      end
      if (j == 8) begin
        total++; if (drop_cnt !== 16'd2 || ovf_sticky !== 3'b110) begin
          bad++; $display("FAIL md_two got drop=%0d ovf=%b want 2/110", drop_cnt, ovf_sticky);
        end
      end
      if (j == 9) begin
        total++; if (drop_cnt !== 16'd5 || ovf_sticky !== 3'b111) begin
          bad++; $display("FAIL md_three got drop=%0d ovf=%b want 5/111", drop_cnt, ovf_sticky);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    logic [LEN-1:0] w;
    do_reset();
    for (int j = 0; j < 6; j++) begin
      mtc[0] = mk(4'h1, 31'h0777_0000 + 31'(j));
      @(posedge clock); #1;
    end
    clear_inputs();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rm_setup got=%b want=1", out_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== 2'd0 || out_procflags !== 4'h0) begin
      bad++; $display("FAIL rm_async got v=%b d=%h ch=%0d pf=%h want 0/0/0/0", out_valid, out_data, out_ch, out_procflags);
    end
`ifdef MTC_RX_FLAG_CNT_EN
    total++; if ({cnt_pass, cnt_below, cnt_other} !== 48'd0) begin
      bad++; $display("FAIL rm_cnt got=%0d/%0d/%0d want=0/0/0", cnt_pass, cnt_below, cnt_other);
    end
`endif
    repeat (2) @(posedge clock);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clock); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_stale got=%b want=0", out_valid); end
    end
    w = mk(4'h6, 31'h0246_8ACE);
    mtc[2] = w;
    @(posedge clock); #1;
    clear_inputs();
    @(posedge clock); #1;
    total++; if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== w[PW-1:0]) begin
      bad++; $display("FAIL rm_resume got v=%b ch=%0d d=%h want v=1 ch=2 d=%h", out_valid, out_ch, out_data, w[PW-1:0]);
    end
  endtask

  initial begin
    out_ready = 1'b0;
    clear_inputs();
    test_reset();
    test_latency();
    test_round_robin();
    test_overflow();
    test_full_pop();
    test_invalid_and_flags();
    test_multi_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
